// File: rtl/addr_ser_dmr.sv
// Digit-serial unsigned adder with duplicated digit datapath, compare and bounded retry.
// Latency: N=WIDTH/DIGIT cycles from acceptance to out_valid, plus N cycles per retry.
// Backpressure: one transaction in flight; in_ready only in IDLE, result held in DONE until out_ready.
module addr_ser_dmr #(
  parameter int WIDTH     = 8,
  parameter int DIGIT     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH:0]                 sum,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retries,
  input  logic                           inj_en,
  input  logic [DIGIT-1:0]               inj_mask
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ca_q, ca_d, cb_q, cb_d;
  logic             mis_q, mis_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             fault_q, fault_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   ra, rb;
  logic             dig_mis;
  logic             pass_mis;

  // Two independent digit adders on the current digit; copy B can be corrupted by the injection hook.
  always_comb begin
    a_dig = a_q[int'(idx_q)*DIGIT +: DIGIT];
    b_dig = b_q[int'(idx_q)*DIGIT +: DIGIT];
    ra    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, ca_q};
    rb    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cb_q};
    if (inj_en) begin
      rb[DIGIT-1:0] = rb[DIGIT-1:0] ^ inj_mask;
    end
    dig_mis  = (ra != rb);
    pass_mis = mis_q | dig_mis;
  end

  // Next-state and datapath update for the IDLE / CALC / DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    mis_d   = mis_q;
    retry_d = retry_q;
    sum_d   = sum_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          ca_d    = 1'b0;
          cb_d    = 1'b0;
          mis_d   = 1'b0;
          retry_d = '0;
          fault_d = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Result always comes from copy A; copy B only serves as the comparison reference.
        sum_d[int'(idx_q)*DIGIT +: DIGIT] = ra[DIGIT-1:0];
        ca_d  = ra[DIGIT];
        cb_d  = rb[DIGIT];
        mis_d = pass_mis;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N - 1)) begin
          sum_d[WIDTH] = ra[DIGIT];
          idx_d = '0;
          ca_d  = 1'b0;
          cb_d  = 1'b0;
          mis_d = 1'b0;
          if (!pass_mis) begin
            fault_d = 1'b0;
            state_d = S_DONE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
          end else begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      ca_q    <= 1'b0;
      cb_q    <= 1'b0;
      mis_q   <= 1'b0;
      retry_q <= '0;
      sum_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      mis_q   <= mis_d;
      retry_q <= retry_d;
      sum_q   <= sum_d;
      fault_q <= fault_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign fault     = fault_q;
  assign retries   = retry_q;

endmodule

// File: tb/tb_addr_ser_dmr.sv
// Scoreboard bench for addr_ser_dmr: driver pushes model results, monitor pops on each new result.
// Model: sum = a+b; a pass is clean unless any of its CALC cycles carries a nonzero injection mask.
// Out_ready driven randomly, forced high, or held low for backpressure.
module tb_addr_ser_dmr;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int MR = 2;
  localparam int N  = W / D;
  localparam int MAXC = (MR + 1) * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   sum;
  logic         fault;
  logic [1:0]   retries;
  logic         inj_en = 1'b0;
  logic [D-1:0] inj_mask = '0;

  addr_ser_dmr #(.WIDTH(W), .DIGIT(D), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .fault(fault), .retries(retries),
    .inj_en(inj_en), .inj_mask(inj_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] s;
    logic       f;
    int         r;
    int         lat;
    int         acc;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           rdy_mode = 1;   // 0 random, 1 always high, 2 held low
  logic [D-1:0] inj_pat [MAXC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer readiness, updated shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (rdy_mode == 2)      out_ready = 1'b0;
    else if (rdy_mode == 1) out_ready = 1'b1;
    else                    out_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor: compare each newly presented result, then check it stays stable while held.
  logic       seen = 1'b0;
  logic [W:0] cap_s;
  logic       cap_f;
  logic [1:0] cap_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        cap_s = sum; cap_f = fault; cap_r = retries;
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("fault", 32'(fault), 32'(e.f));
          chk("retries", 32'(retries), 32'(e.r));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("in_ready_in_done", 32'(in_ready), 32'(0));
        end
      end else begin
        chk("hold_sum", 32'(sum), 32'(cap_s));
        chk("hold_fault", 32'(fault), 32'(cap_f));
        chk("hold_retries", 32'(retries), 32'(cap_r));
      end
    end else begin
      seen = 1'b0;
    end
  end

  // Issue one transaction using the current injection pattern; returns after the injection window.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb2);
    int   t;
    exp_t e;
    logic found;
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      chk("wait_in_ready", 32'(in_ready), 32'(1));
      return;
    end
    a = ta; b = tb2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.acc = cyc;
    e.s   = {1'b0, ta} + {1'b0, tb2};
    e.f   = 1'b1;
    e.r   = MR;
    e.lat = MAXC;
    found = 1'b0;
    for (int p = 0; p <= MR; p++) begin
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < N; k++) if (inj_pat[p*N + k] != '0) bad = 1'b1;
      if (!bad && !found) begin
        found = 1'b1; e.f = 1'b0; e.r = p; e.lat = (p + 1) * N;
      end
    end
    sb.push_back(e);
    for (int c = 0; c < MAXC; c++) begin
      inj_en = (inj_pat[c] != '0); inj_mask = inj_pat[c];
      @(posedge clk); #1;
    end
    inj_en = 1'b0; inj_mask = '0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((out_valid || !in_ready) && t < 300) begin @(posedge clk); #1; t++; end
    if (out_valid || !in_ready) chk("drain_timeout", 32'(in_ready), 32'(1));
  endtask

  task automatic clr_pat();
    for (int c = 0; c < MAXC; c++) inj_pat[c] = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr_pat();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_fault", 32'(fault), 32'(0));
    chk("rst_retries", 32'(retries), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with an always-ready consumer.
    rdy_mode = 1;
    do_txn(8'd200, 8'd100); wait_idle();
    do_txn(8'd255, 8'd255); wait_idle();
    do_txn(8'd0, 8'd0); wait_idle();
    inj_pat[0] = 4'h1;
    do_txn(8'd15, 8'd1); wait_idle();
    for (int c = 0; c < MAXC; c++) inj_pat[c] = 4'h8;
    do_txn(8'd18, 8'd52); wait_idle();
    clr_pat();

    // Backpressure: result held, new in_valid ignored.
    rdy_mode = 2;
    do_txn(8'd77, 8'd99);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
      chk("bp_result_ready", 32'(out_valid), 32'(1));
    end
    a = 8'd1; b = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready_low", 32'(in_ready), 32'(0));
      chk("bp_out_valid_held", 32'(out_valid), 32'(1));
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(out_valid), 32'(0));
    chk("bp_release_in_ready", 32'(in_ready), 32'(1));

    // Reset during the second CALC cycle aborts the transaction.
    a = 8'd5; b = 8'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_sum", 32'(sum), 32'(0));
    chk("mid_rst_fault", 32'(fault), 32'(0));
    chk("mid_rst_retries", 32'(retries), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(8'd1, 8'd2); wait_idle();

    // Randomized operands, injection patterns and consumer readiness.
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      int kind;
      clr_pat();
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        inj_pat[$urandom_range(0, N - 1)] = D'($urandom_range(1, 15));
      end else if (kind == 2) begin
        for (int c = 0; c < MAXC; c++)
          if ($urandom_range(0, 4) == 0) inj_pat[c] = D'($urandom_range(1, 15));
      end else if (kind == 3) begin
        for (int c = 0; c < MAXC; c++) inj_pat[c] = D'($urandom_range(1, 15));
      end
      do_txn(W'($urandom), W'($urandom));
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
